// File: rtl/pipe_gen.sv
// Scrolling pipe generator: moves one pipe across 16 columns, picks gap rows, counts passes.
// Define PIPE_GAP_RANDOM_EN to draw gaps from a 4-bit LFSR instead of the fixed 2,6,10,4 sequence.
module pipe_gen #(
  parameter int         GAP_SIZE  = 4,
  parameter logic [3:0] BIRD_X    = 4'd12,
  parameter logic [3:0] LFSR_SEED = 4'b1001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tick,
  input  logic       Run,
  input  logic       Hit,
  output logic [3:0] PipeX,
  output logic [3:0] GapY,
  output logic       PipeValid,
  output logic       Passed,
  output logic [7:0] PipeCount
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCROLL = 2'd1;
  localparam logic [1:0] FROZEN = 2'd2;

  // The gap mapping only keeps gaps of up to 4 rows on screen; a zero seed would lock the LFSR.
  if (GAP_SIZE < 1 || GAP_SIZE > 4) begin : g_gap_size_check
    $error("pipe_gen: GAP_SIZE must be 1..4");
  end
  if (LFSR_SEED == 4'd0) begin : g_seed_check
    $error("pipe_gen: LFSR_SEED must be non-zero");
  end

  logic [1:0] state;
  logic [3:0] gap_src;
  logic       advance;

  function automatic logic [3:0] gap_map(input logic [3:0] src);
    return (src > 4'd12) ? (src - 4'd4) : src;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : (cnt + 8'd1);
  endfunction

  // Gap source steps exactly when a new gap is latched: on game start and on every wrap.
  assign advance = Run && ((state == IDLE) ||
                           (state == SCROLL && !Hit && Tick && PipeX == 4'd15));

`ifdef PIPE_GAP_RANDOM_EN
  logic [3:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end

  assign gap_src = lfsr;
`else
  logic [1:0] gap_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_idx <= 2'd0;
    end else if (advance) begin
      gap_idx <= gap_idx + 2'd1;
    end
  end

  always_comb begin
    gap_src = 4'd2;
    case (gap_idx)
      2'd0: gap_src = 4'd2;
      2'd1: gap_src = 4'd6;
      2'd2: gap_src = 4'd10;
      2'd3: gap_src = 4'd4;
      default: gap_src = 4'd2;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      PipeX     <= 4'd0;
      GapY      <= 4'd0;
      Passed    <= 1'b0;
      PipeCount <= 8'd0;
    end else begin
      Passed <= 1'b0;
      case (state)
        IDLE: begin
          PipeX <= 4'd0;
          if (Run) begin
            state     <= SCROLL;
            GapY      <= gap_map(gap_src);
            PipeCount <= 8'd0;
          end
        end
        SCROLL: begin
          // Run drop beats Hit, and Hit beats Tick.
          if (!Run) begin
            state <= IDLE;
            PipeX <= 4'd0;
          end else if (Hit) begin
            state <= FROZEN;
          end else if (Tick) begin
            PipeX <= PipeX + 4'd1;
            if (PipeX == 4'd15) begin
              GapY <= gap_map(gap_src);
            end
            if (PipeX == BIRD_X) begin
              Passed    <= 1'b1;
              PipeCount <= sat_inc(PipeCount);
            end
          end
        end
        FROZEN: begin
          if (!Run) begin
            state <= IDLE;
            PipeX <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
          PipeX <= 4'd0;
        end
      endcase
    end
  end

  assign PipeValid = (state != IDLE);

endmodule

// File: tb/tb_pipe_gen.sv
// Directed bench for pipe_gen: a vector table for reset/start/freeze, then hand sequences
// for passing, freeze priority, mid-scroll reset, gap sequencing and count saturation.
module tb_pipe_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Tick = 1'b0;
  logic       Run = 1'b0;
  logic       Hit = 1'b0;
  logic [3:0] PipeX;
  logic [3:0] GapY;
  logic       PipeValid;
  logic       Passed;
  logic [7:0] PipeCount;

  int checks = 0;
  int failures = 0;

  pipe_gen dut (
    .clk(clk), .reset(reset), .Tick(Tick), .Run(Run), .Hit(Hit),
    .PipeX(PipeX), .GapY(GapY), .PipeValid(PipeValid),
    .Passed(Passed), .PipeCount(PipeCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       run;
    logic       tick;
    logic       hit;
    logic [3:0] x;
    logic [3:0] g;
    logic       v;
    logic       p;
    logic [7:0] c;
  } vec_t;

  vec_t       vecs[11];
  logic [3:0] gexp[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic ru, input logic t, input logic h);
    reset = r; Run = ru; Tick = t; Hit = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int x, input int g, input int v,
                         input int p, input int c);
    chk({tag, ".PipeX"}, PipeX, x);
    chk({tag, ".GapY"}, GapY, g);
    chk({tag, ".PipeValid"}, PipeValid, v);
    chk({tag, ".Passed"}, Passed, p);
    chk({tag, ".PipeCount"}, PipeCount, c);
  endtask

  initial begin
`ifdef PIPE_GAP_RANDOM_EN
    // LFSR 9 -> 3 -> 6 -> 13 -> 10; 13 maps down to 9
    gexp[0] = 4'd9; gexp[1] = 4'd3; gexp[2] = 4'd6; gexp[3] = 4'd9; gexp[4] = 4'd10;
`else
    gexp[0] = 4'd2; gexp[1] = 4'd6; gexp[2] = 4'd10; gexp[3] = 4'd4; gexp[4] = 4'd2;
`endif
    //          rst   run   tick  hit   x     g         v     p     c
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,     1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0,     1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, gexp[0],  1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, gexp[0],  1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1, gexp[0],  1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, gexp[0],  1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd2, gexp[0],  1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, gexp[0],  1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, gexp[0],  1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, gexp[0],  1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, gexp[1],  1'b1, 1'b0, 8'd0};

    #1;
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].run, vecs[i].tick, vecs[i].hit);
      chk_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].g, vecs[i].v, vecs[i].p, vecs[i].c);
    end

    // Walk up to the bird column, then cross it
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("approach%0d.PipeX", i), PipeX, i);
      chk($sformatf("approach%0d.Passed", i), Passed, 0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("pass", 13, gexp[1], 1, 1, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("pass_after", 13, gexp[1], 1, 0, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("x15.PipeX", PipeX, 15);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("wrap1", 0, gexp[2], 1, 0, 1);

    // Hit together with Tick freezes at column 5
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_hit.PipeX", PipeX, 5);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk_all("hit", 5, gexp[2], 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_all($sformatf("frozen%0d", i), 5, gexp[2], 1, 0, 1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("frozen_stop", 0, gexp[2], 0, 0, 1);
    step(1'b0, 1'b1, 1'b0, 0);
    chk_all("restart", 0, gexp[3], 1, 0, 0);

    // Reset mid-scroll at column 9, then immediate restart
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_reset.PipeX", PipeX, 9);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("mid_reset", 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("post_reset_run", 0, gexp[0], 1, 0, 0);

    // Four full wraps
    for (int w = 1; w <= 4; w++) begin
      for (int k = 1; k <= 16; k++) begin
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk($sformatf("w%0dk%0d.PipeX", w, k), PipeX, k % 16);
        chk($sformatf("w%0dk%0d.Passed", w, k), Passed, (k == 13) ? 1 : 0);
      end
      chk($sformatf("wrap%0d.GapY", w), GapY, gexp[w]);
      chk($sformatf("wrap%0d.PipeCount", w), PipeCount, w);
    end

    // Drive well past 255 passes; the count must stick at 255
    for (int w = 0; w < 260; w++) begin
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    chk("saturate.PipeCount", PipeCount, 255);
    for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sat_pass.Passed", Passed, 1);
    chk("sat_pass.PipeCount", PipeCount, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_gen.md
PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 Parameter GAP_SIZE, default 4: vertical gap height in rows; kept for documentation and bench checks only, with no effect on outputs.
REQ-002 Parameter BIRD_X, default 4'd12: fixed bird column used for pass detection.
REQ-003 Parameter LFSR_SEED, default 4'b1001: non-zero LFSR reset value.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Tick  input  1  one-cycle game-step strobe; pipe advances only on Tick.
REQ-007 Run  input  1  game running level; low returns block to IDLE.
REQ-008 Hit  input  1  collision flag from the collision detector; freezes the pipe.
REQ-009 PipeX  output  4  current pipe column, registered.
REQ-010 GapY  output  4  top row of current gap, registered, range 0..12.
REQ-011 PipeValid  output  1  high in SCROLL and FROZEN, i.e. whenever a pipe is on screen.
REQ-012 Passed  output  1  one-cycle pulse when the pipe clears the bird column.
REQ-013 PipeCount  output  8  number of pipes passed; saturates at 255.

Function
REQ-014 FSM states: IDLE, SCROLL, FROZEN; encoding is free.
REQ-015 IDLE: PipeX=0, PipeValid=0, Passed=0, and PipeCount is held.
REQ-016 IDLE with Run=1 -> SCROLL next cycle; on that edge GapY loads from the gap source, LFSR advances, PipeX=0, and PipeCount clears to 0.
REQ-017 SCROLL, Tick=1, Hit=0, PipeX<15: PipeX increments by 1.
REQ-018 SCROLL, Tick=1, Hit=0, PipeX==15: PipeX wraps to 0, GapY loads a new value, and the LFSR advances, all on the same edge.
REQ-019 Tick=0: PipeX, GapY and LFSR hold.
REQ-020 SCROLL, Tick=1, Hit=0, PipeX==BIRD_X: Passed=1 for exactly the following cycle; PipeCount increments by 1 on the same edge unless it is 255.
REQ-021 SCROLL with Hit=1 -> FROZEN next cycle; Hit has priority over a simultaneous Tick, so there is no move, no Passed and no count.
REQ-022 FROZEN: PipeX, GapY and PipeCount hold; Tick is ignored; PipeValid=1.
REQ-023 Run=0 in SCROLL or FROZEN -> IDLE next cycle; this has priority over Hit and Tick.
REQ-024 LFSR: 4-bit, next = {lfsr[2:0], lfsr[3]^lfsr[2]}; never reaches 0.
REQ-025 Gap mapping: GapY = (src>12) ? src-4 : src, so GapY+GAP_SIZE never exceeds 16.
REQ-026 Passed is registered; it is never high in IDLE or FROZEN, or for two consecutive cycles.

Reset
REQ-027 reset=1 at a clock edge forces: state IDLE, PipeX=0, GapY=0, PipeValid=0, Passed=0, PipeCount=0, LFSR=LFSR_SEED.
REQ-028 Reset has priority over every other input, including mid-scroll and FROZEN.
REQ-029 Run=1 is honoured on the first edge after reset deasserts.

Configuration
REQ-030 Macro PIPE_GAP_RANDOM_EN defined: the gap source is the LFSR value, per REQ-024/025.
REQ-031 Macro PIPE_GAP_RANDOM_EN undefined: the gap source is a 2-bit index into the fixed sequence 2,6,10,4, repeating. The index resets to 0 and advances wherever the LFSR would advance. The LFSR logic is absent. All other behaviour is identical.

Verification
REQ-032 Reset, then Run=1 for 1 cycle (macro defined) -> PipeValid=1, PipeX=0, GapY=9; the first wrap gives GapY=3.
REQ-033 SCROLL, 12 Ticks then 1 more Tick -> PipeX=13, Passed high exactly 1 cycle, PipeCount=1.
REQ-034 SCROLL at PipeX=5, Hit=1 and Tick=1 same cycle -> FROZEN, PipeX stays 5; 3 further Ticks leave PipeX=5 and Passed=0.
REQ-035 FROZEN, Run=0 -> IDLE, PipeX=0, PipeValid=0, PipeCount held; Run=1 -> PipeCount=0.
REQ-036 Macro undefined, 4 full wraps (64 Ticks) -> GapY sequence 2,6,10,4,2; PipeCount=4.
REQ-037 reset=1 asserted at PipeX=9 mid-scroll -> all outputs at reset values next cycle; LFSR restarts from 4'b1001.
